sar_ctrl_scan: RTL and testbench

Parametrised successor to the single-channel SAR controller; drives the CDAC (RST, HOLD, trial code) and comparator enable.
Adds multi-channel scan sequencing driven by a channel mask, single-shot or continuous scan, and per-channel tagged results with a valid strobe.
Sits between the system bus and the analog ADC macro (CDAC, comparator, input mux).

---
 rtl/sar_ctrl_scan_if.sv | 39 +++
 rtl/sar_ctrl_scan.sv | 208 ++++++++++++++++++++
 tb/tb_sar_ctrl_scan.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sar_ctrl_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : sar_ctrl_scan_if
// Brief    : Control/status bundle between the scan SAR controller and its host
//            (the host side also models the comparator and the CDAC).
// Revision : 1.0 - initial release
// ============================================================================
interface sar_ctrl_scan_if #(
  parameter int SIZE = 12,
  parameter int NCH  = 4,
  parameter int CH_W = 2
);
  logic            en;
  logic            soc;
  logic            cont;
  logic [NCH-1:0]  chan_mask;
  logic [3:0]      swidth;
  logic            cmp;
  logic            sample_n;
  logic            dac_rst;
  logic [SIZE-1:0] data;
  logic [CH_W-1:0] ch;
  logic            busy;
  logic [SIZE-1:0] result;
  logic [CH_W-1:0] result_ch;
  logic            result_valid;
  logic            eoc;

  modport master (
    output en, soc, cont, chan_mask, swidth, cmp,
    input  sample_n, dac_rst, data, ch, busy, result, result_ch, result_valid, eoc
  );

  modport slave (
    input  en, soc, cont, chan_mask, swidth, cmp,
    output sample_n, dac_rst, data, ch, busy, result, result_ch, result_valid, eoc
  );
endinterface
`default_nettype wire

// File: rtl/sar_ctrl_scan.sv
`default_nettype none
// ============================================================================
// Module   : sar_ctrl_scan
// Brief    : Multi-channel SAR controller: mask-driven scan, single or
//            continuous, tagged results. Optional macro SAR_AVG_EN averages
//            2^AVG_LOG2 conversions per channel.
// Revision : 1.0 - initial release
// ============================================================================
module sar_ctrl_scan #(
  parameter int SIZE     = 12,
  parameter int NCH      = 4,
  parameter int CH_W     = 2,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  sar_ctrl_scan_if.slave   bus
);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_sample  = 2'd1;
  localparam logic [1:0] c_convert = 2'd2;
  localparam logic [1:0] c_done    = 2'd3;

  localparam logic [SIZE-1:0] c_msb = {1'b1, {(SIZE-1){1'b0}}};

  logic [1:0]      r_state;
  logic [1:0]      w_state_next;
  logic [NCH-1:0]  r_mask;
  logic            r_cont;
  logic [CH_W-1:0] r_ch;
  logic [3:0]      r_scnt;
  logic [SIZE-1:0] r_data;
  logic [SIZE-1:0] r_bit;
  logic [SIZE-1:0] r_result;
  logic [CH_W-1:0] r_result_ch;

  logic            w_start;
  logic [SIZE-1:0] w_code;
  logic [SIZE-1:0] w_final;
  logic            w_avg_last;
  logic            w_next_found;
  logic [CH_W-1:0] w_next_ch;
  logic            w_sample_entry;

  logic            w_sample_n;
  logic            w_dac_rst;
  logic            w_busy;
  logic            w_result_valid;
  logic            w_eoc;

  function automatic logic [CH_W-1:0] lowest(input logic [NCH-1:0] m);
    lowest = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) lowest = CH_W'(i);
    end
  endfunction

  assign w_start = bus.en & bus.soc & (|bus.chan_mask);

  // Decision on the current trial bit; lower bits are still zero here.
  assign w_code = bus.cmp ? r_data : (r_data & ~r_bit);

  assign w_sample_entry = (w_state_next == c_sample) && (r_state != c_sample);

  always_comb begin
    w_next_found = 1'b0;
    w_next_ch    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (r_mask[i] && (i > int'(r_ch))) begin
        w_next_found = 1'b1;
        w_next_ch    = CH_W'(i);
      end
    end
  end

`ifdef SAR_AVG_EN
  localparam int c_acc_w = SIZE + AVG_LOG2;
  localparam int c_cnt_w = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [c_acc_w-1:0] r_acc;
  logic [c_cnt_w-1:0] r_avg_cnt;
  logic [c_acc_w-1:0] w_acc_sum;

  assign w_acc_sum  = r_acc + c_acc_w'(w_code);
  assign w_avg_last = (r_avg_cnt == c_cnt_w'((1 << AVG_LOG2) - 1));
  assign w_final    = SIZE'(w_acc_sum >> AVG_LOG2);

  // Sum restarts whenever a new channel begins sampling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_avg_cnt <= '0;
    end else if (w_sample_entry && (r_state != c_convert)) begin
      r_acc     <= '0;
      r_avg_cnt <= '0;
    end else if ((r_state == c_convert) && (w_state_next == c_sample)) begin
      r_acc     <= w_acc_sum;
      r_avg_cnt <= r_avg_cnt + 1'b1;
    end
  end
`else
  logic w_unused_avg;

  assign w_unused_avg = |AVG_LOG2;
  assign w_avg_last   = 1'b1;
  assign w_final      = w_code;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_idle;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle: begin
        if (w_start) w_state_next = c_sample;
      end
      c_sample: begin
        if (!bus.en)              w_state_next = c_idle;
        else if (r_scnt == 4'd0)  w_state_next = c_convert;
      end
      c_convert: begin
        if (!bus.en)       w_state_next = c_idle;
        else if (r_bit[0]) w_state_next = w_avg_last ? c_done : c_sample;
      end
      c_done: begin
        if (!bus.en)                    w_state_next = c_idle;
        else if (w_next_found || r_cont) w_state_next = c_sample;
        else                            w_state_next = c_idle;
      end
      default: w_state_next = c_idle;
    endcase
  end

  // Output decode
  always_comb begin
    w_sample_n     = (r_state != c_sample);
    w_dac_rst      = (r_state == c_idle);
    w_busy         = (r_state != c_idle);
    w_result_valid = (r_state == c_done) && bus.en;
    w_eoc          = (r_state == c_done) && bus.en && !w_next_found;
  end

  // Scan bookkeeping, sample timer and successive-approximation register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask      <= '0;
      r_cont      <= 1'b0;
      r_ch        <= '0;
      r_scnt      <= 4'd0;
      r_data      <= '0;
      r_bit       <= '0;
      r_result    <= '0;
      r_result_ch <= '0;
    end else begin
      if ((r_state == c_idle) && w_start) begin
        r_mask <= bus.chan_mask;
        r_cont <= bus.cont;
        r_ch   <= lowest(bus.chan_mask);
      end else if ((r_state == c_done) && (w_state_next == c_sample)) begin
        r_ch <= w_next_found ? w_next_ch : lowest(r_mask);
      end else if (w_state_next == c_idle) begin
        r_ch <= '0;
      end

      if (w_sample_entry) begin
        r_scnt <= (bus.swidth == 4'd0) ? 4'd0 : (bus.swidth - 4'd1);
      end else if ((r_state == c_sample) && (r_scnt != 4'd0)) begin
        r_scnt <= r_scnt - 4'd1;
      end

      if (w_state_next == c_convert) begin
        if (r_state == c_convert) begin
          r_data <= w_code | (r_bit >> 1);
          r_bit  <= r_bit >> 1;
        end else begin
          r_data <= c_msb;
          r_bit  <= c_msb;
        end
      end else begin
        r_data <= '0;
        r_bit  <= '0;
      end

      if ((r_state == c_convert) && (w_state_next == c_done)) begin
        r_result    <= w_final;
        r_result_ch <= r_ch;
      end
    end
  end

  assign bus.sample_n     = w_sample_n;
  assign bus.dac_rst      = w_dac_rst;
  assign bus.data         = r_data;
  assign bus.ch           = r_ch;
  assign bus.busy         = w_busy;
  assign bus.result       = r_result;
  assign bus.result_ch    = r_result_ch;
  assign bus.result_valid = w_result_valid;
  assign bus.eoc          = w_eoc;

endmodule
`default_nettype wire

// File: tb/tb_sar_ctrl_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_ctrl_scan
// Brief    : Directed self-checking bench for sar_ctrl_scan with an ideal
//            comparator model (cmp = vin >= data).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_ctrl_scan;
  localparam int SIZE     = 12;
  localparam int NCH      = 4;
  localparam int CH_W     = 2;
  localparam int AVG_LOG2 = 2;
`ifdef SAR_AVG_EN
  localparam int NAVG = 4;
`else
  localparam int NAVG = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sar_ctrl_scan_if #(.SIZE(SIZE), .NCH(NCH), .CH_W(CH_W)) bus ();

  sar_ctrl_scan #(.SIZE(SIZE), .NCH(NCH), .CH_W(CH_W), .AVG_LOG2(AVG_LOG2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [11:0] vin [4];
  logic        alt_en = 1'b0;
  int          conv_cnt = 0;
  logic [11:0] w_vin;
  logic [11:0] trace [0:255];

  always @(negedge bus.sample_n) conv_cnt++;

  always_comb begin
    w_vin = vin[bus.ch];
    if (alt_en) w_vin = conv_cnt[0] ? 12'h103 : 12'h100;
  end
  assign bus.cmp = (w_vin >= bus.data);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input logic [3:0] m, input logic [3:0] sw, input logic c);
    bus.chan_mask = m;
    bus.swidth    = sw;
    bus.cont      = c;
    bus.soc       = 1'b1;
    tick();
    bus.soc       = 1'b0;
  endtask

  // Cycles until the next result_valid, plus how many of them had sample_n low.
  task automatic wait_valid(output int n, output int nlow);
    n = 0;
    nlow = 0;
    do begin
      trace[n[7:0]] = bus.data;
      if (!bus.sample_n) nlow++;
      tick();
      n++;
    end while (!bus.result_valid && n < 200);
    check("valid_seen", {31'd0, bus.result_valid}, 32'd1);
  endtask

  int n, nlow, nv;

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b0; bus.soc = 1'b0; bus.cont = 1'b0;
    bus.chan_mask = '0; bus.swidth = 4'd4;
    for (int i = 0; i < 4; i++) vin[i] = 12'h000;
    tick(); tick();
    check("rst_sample_n", {31'd0, bus.sample_n}, 32'd1);
    check("rst_dac_rst",  {31'd0, bus.dac_rst}, 32'd1);
    check("rst_data",     {20'd0, bus.data}, 32'd0);
    check("rst_busy",     {31'd0, bus.busy}, 32'd0);
    check("rst_result",   {20'd0, bus.result}, 32'd0);
    check("rst_valid_eoc", {30'd0, bus.result_valid, bus.eoc}, 32'd0);
    rst_n = 1'b1;
    tick();
    bus.en = 1'b1;

    // Single channel binary search
    vin[0] = 12'hA5C;
    start_scan(4'b0001, 4'd4, 1'b0);
    check("t1_busy", {31'd0, bus.busy}, 32'd1);
    wait_valid(n, nlow);
    check("t1_lat",    n, NAVG * 16);
    check("t1_nlow",   nlow, NAVG * 4);
    check("t1_trial0", {20'd0, trace[4]}, 32'h800);
    check("t1_trial1", {20'd0, trace[5]}, 32'hC00);
    check("t1_trial2", {20'd0, trace[6]}, 32'hA00);
    check("t1_result", {20'd0, bus.result}, 32'hA5C);
    check("t1_rch",    {30'd0, bus.result_ch}, 32'd0);
    check("t1_eoc",    {31'd0, bus.eoc}, 32'd1);
    tick();
    check("t1_idle_busy", {31'd0, bus.busy}, 32'd0);
    check("t1_idle_rst",  {31'd0, bus.dac_rst}, 32'd1);

    // Two-channel scan
    vin[1] = 12'h123; vin[3] = 12'hFFF;
    start_scan(4'b1010, 4'd4, 1'b0);
    check("t2_ch", {30'd0, bus.ch}, 32'd1);
    wait_valid(n, nlow);
    check("t2_lat_a", n, NAVG * 16);
    check("t2_res_a", {20'd0, bus.result}, 32'h123);
    check("t2_rch_a", {30'd0, bus.result_ch}, 32'd1);
    check("t2_eoc_a", {31'd0, bus.eoc}, 32'd0);
    wait_valid(n, nlow);
    check("t2_lat_b", n, NAVG * 16 + 1);
    check("t2_res_b", {20'd0, bus.result}, 32'hFFF);
    check("t2_rch_b", {30'd0, bus.result_ch}, 32'd3);
    check("t2_eoc_b", {31'd0, bus.eoc}, 32'd1);
    tick();

    // Edge codes and minimum sample width
    vin[0] = 12'h000;
    start_scan(4'b0001, 4'd4, 1'b0);
    wait_valid(n, nlow);
    check("t3_zero", {20'd0, bus.result}, 32'h000);
    tick();
    vin[0] = 12'hFFF;
    start_scan(4'b0001, 4'd4, 1'b0);
    wait_valid(n, nlow);
    check("t3_full", {20'd0, bus.result}, 32'hFFF);
    tick();
    vin[0] = 12'h3C3;
    start_scan(4'b0001, 4'd0, 1'b0);
    wait_valid(n, nlow);
    check("t3_sw0_nlow", nlow, NAVG * 1);
    check("t3_sw0_lat",  n, NAVG * 13);
    check("t3_sw0_res",  {20'd0, bus.result}, 32'h3C3);
    tick();

    // Continuous mode, then abort mid-conversion
    vin[0] = 12'hA5C;
    start_scan(4'b0001, 4'd4, 1'b1);
    wait_valid(n, nlow);
    check("t4_lat_a", n, NAVG * 16);
    check("t4_eoc_a", {31'd0, bus.eoc}, 32'd1);
    wait_valid(n, nlow);
    check("t4_lat_b", n, NAVG * 16 + 1);
    check("t4_res_b", {20'd0, bus.result}, 32'hA5C);
    repeat (8) tick();
    check("t4_in_conv", {30'd0, bus.busy, bus.sample_n}, 32'd3);
    bus.en = 1'b0;
    tick();
    check("t4_abort_busy", {31'd0, bus.busy}, 32'd0);
    check("t4_abort_rst",  {31'd0, bus.dac_rst}, 32'd1);
    check("t4_abort_data", {20'd0, bus.data}, 32'd0);
    nv = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.result_valid || bus.eoc) nv++;
      tick();
    end
    check("t4_no_valid", nv, 0);
    check("t4_hold_res", {20'd0, bus.result}, 32'hA5C);
    bus.en = 1'b1;
    bus.cont = 1'b0;

    // Empty mask ignored; soc and mask/cont changes while busy ignored
    start_scan(4'b0000, 4'd4, 1'b0);
    check("t5_mask0", {31'd0, bus.busy}, 32'd0);
    vin[0] = 12'h5A5;
    start_scan(4'b0001, 4'd4, 1'b0);
    bus.soc = 1'b1; bus.chan_mask = 4'b1000; bus.cont = 1'b1;
    repeat (3) tick();
    bus.soc = 1'b0;
    wait_valid(n, nlow);
    check("t5_lat", n, NAVG * 16 - 3);
    check("t5_res", {20'd0, bus.result}, 32'h5A5);
    check("t5_eoc", {31'd0, bus.eoc}, 32'd1);
    tick();
    check("t5_idle", {31'd0, bus.busy}, 32'd0);

    // Asynchronous reset during SAMPLE
    start_scan(4'b0001, 4'd4, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_sample_n", {31'd0, bus.sample_n}, 32'd1);
    check("t6_dac_rst",  {31'd0, bus.dac_rst}, 32'd1);
    check("t6_busy",     {31'd0, bus.busy}, 32'd0);
    check("t6_ch",       {30'd0, bus.ch}, 32'd0);
    check("t6_result",   {20'd0, bus.result}, 32'd0);
    check("t6_rch_strb", {29'd0, bus.result_ch, bus.result_valid}, 32'd0);
    #3;
    rst_n = 1'b1;
    tick();

`ifdef SAR_AVG_EN
    alt_en = 1'b1;
    start_scan(4'b0001, 4'd4, 1'b0);
    wait_valid(n, nlow);
    check("t7_avg_lat", n, 64);
    check("t7_avg_res", {20'd0, bus.result}, 32'h101);
    tick();
    alt_en = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
